alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
Shares one 16-bit ALU datapath between two independent requesters, e.g. the instruction sequencer and the address/loop unit.
- Arbitration is round-robin.
- Operands and opcode are captured through a valid/ready handshake.
- The operation executes in one cycle, and the result is held in a single output register tagged with the requester ID until the consumer accepts it.

Parameters:
DATA_W, 16, operand/result width (shift amount always uses operand_b[3:0]; only 16 is required to be supported)
NUM_REQ, 2, number of requesters (fixed at 2; ID is 1 bit)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous active-low
req_valid  input  2  bit i: requester i presents an operation
req_ready  output  2  bit i: operation of requester i accepted this cycle (the grant)
req_a  input  32  {a1, a0}: operand A per requester, 16 bits each
req_b  input  32  {b1, b0}: operand B per requester
req_op  input  6  {op1, op0}: 3-bit opcode per requester
rsp_valid  output  1  result register holds a valid result
rsp_ready  input  1  consumer accepts the result
rsp_data  output  16  result
rsp_id  output  1  requester that issued the result
busy  output  1  rsp_valid held while rsp_ready is low (stall indicator)

Behaviour:
- One clock, asynchronous active-low reset: clk, rst_n.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, priority pointer=0 (requester 0 first), req_ready=0, busy=0. Reset mid-operation discards any held result; nothing is replayed.
- Opcode encoding (3 bits):
  - 0 ADD: a+b mod 2^16
  - 1 SUB: a-b mod 2^16
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: a<<b[3:0]
  - 6 SHR: logical, a>>b[3:0]
  - 7 CMP (unsigned): 16'd1 if a>b, 16'd2 if a<b, 16'd0 if equal
- Operand handling: all operations are unsigned; no carry or flag outputs.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Grant (combinational, from registered pointer and req_valid):
  - If slot_free and exactly one req_valid is set, grant it.
  - If both are set, grant the pointer's requester.
  - At most one req_ready bit is high; req_ready is never high while the slot is not free.
- Accept: on a cycle with req_ready[i]=1:
  - Next edge: rsp_data <= ALU(a_i, b_i, op_i), rsp_id <= i, rsp_valid <= 1, pointer <= ~i.
  - Latency: request accepted at edge N, result visible after edge N (one cycle). Operands are used in the accept cycle only; the requester may change them afterwards.
- Consume: rsp_valid && rsp_ready with no accept in the same cycle -> rsp_valid <= 0 next edge. rsp_data and rsp_id keep their last values.
- Simultaneous consume + accept: back-to-back throughput of 1 op/cycle. rsp_valid stays 1 and the new result replaces the old.
- Hold: while rsp_valid && !rsp_ready, rsp_data and rsp_id are stable and req_ready=0. busy=1 exactly in this condition.
- Fairness:
  - The pointer updates only on a grant; no grant -> pointer unchanged.
  - With both requesters continuously valid and the output always consumed, grants strictly alternate 0,1,0,1.
- req_valid dropped without a grant: no state change. Requesters must hold valid/operands until ready (protocol rule; the arbiter does not check it).
- State machine (2 states, from rsp_valid):
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept+consume or stall.
  - FULL -> EMPTY on consume without accept.

Decomposition:
- Shared package alu_pkg:
  - 3-bit opcode localparams ALU_ADD..ALU_CMP
  - DATA_W
  - CMP result constants CMP_GT=1, CMP_LT=2, CMP_EQ=0
- One sub-module, alu_exec: purely combinational op evaluation per the encoding above.
- Arbitration, pointer and output register stay in alu_share_arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-stall with rsp_valid=1 -> rsp_valid=0, rsp_data=0, pointer=0 immediately (asynchronous), without waiting for a clock edge.
- Single requester: req0 ADD 0xFFFF+0x0002 -> req_ready=01 for one cycle; next cycle rsp_valid=1, rsp_data=0x0001, rsp_id=0.
- Contention: both valid from reset, rsp_ready=1, req0 SUB 5-7, req1 SHL 0x0001<<0x0013 ->
  - first rsp_id=0, rsp_data=0xFFFE
  - second rsp_id=1, rsp_data=0x0008
  - grants alternate over 6 cycles.
- Backpressure: rsp_ready=0 for 3 cycles with req1 pending -> req_ready=00, busy=1, rsp_data stable. rsp_ready=1 -> req1 granted the same cycle; result follows one cycle later.
- CMP/logic sweep:
  - CMP(0x8000,0x0001)=1, CMP(3,9)=2, CMP(7,7)=0
  - SHR 0x8000>>15=0x0001
  - XOR 0xAAAA^0xFFFF=0x5555
- Throughput: rsp_ready held 1, req0 continuously valid, req1 idle -> a grant and a new result every cycle; rsp_valid never drops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: widths, opcodes,
// compare result codes and the output-slot state encoding.
package alu_pkg;

    localparam int DATA_W  = 16;
    localparam int NUM_REQ = 2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SHL = 3'd5;
    localparam logic [2:0] ALU_SHR = 3'd6;
    localparam logic [2:0] ALU_CMP = 3'd7;

    localparam logic [DATA_W-1:0] CMP_EQ = 16'd0;
    localparam logic [DATA_W-1:0] CMP_GT = 16'd1;
    localparam logic [DATA_W-1:0] CMP_LT = 16'd2;

    // Output register occupancy: EMPTY means rsp_valid=0, FULL means rsp_valid=1.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of request and response signals between the requesters/consumer
// (master side) and the shared ALU arbiter (slave side).
//
// Handshake: a request transfers on a cycle where req_valid[i] and
// req_ready[i] are both high; the requester holds req_valid[i] and its
// operands until then. A result transfers on a cycle where rsp_valid and
// rsp_ready are both high; rsp_data/rsp_id are stable while rsp_valid is
// high and rsp_ready is low.
interface alu_share_arbiter_if;
    import alu_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*3-1:0]      req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_id;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/alu_exec.sv
// Single-cycle combinational ALU: unsigned arithmetic, logic, shifts and
// a three-way unsigned compare. Shift amounts come from b[3:0] only.
module alu_exec
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);

    // Evaluate the selected operation.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SHL: y = a << b[3:0];
            ALU_SHR: y = a >> b[3:0];
            ALU_CMP: y = (a > b) ? CMP_GT : ((a < b) ? CMP_LT : CMP_EQ);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. The granted
// operation is evaluated in the accept cycle and its result is held in a
// single output register, tagged with the requester id, until consumed.
module alu_share_arbiter
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus,
    output arb_state_e          state_dbg,
    output logic                ptr_dbg
);

    arb_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              id_q, id_d;

    logic [1:0]        grant;
    logic              slot_free;
    logic              accept;
    logic              sel;
    logic [DATA_W-1:0] a_sel, b_sel, alu_y;
    logic [2:0]        op_sel;

    // The slot can take a new result when empty or being drained this cycle.
    assign slot_free = (state_q == ST_EMPTY) || bus.rsp_ready;

    // Grant: a lone requester wins outright; on contention the pointer decides.
    always_comb begin
        grant = 2'b00;
        if (slot_free) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept = |grant;
    assign sel    = grant[1];
    assign a_sel  = sel ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
    assign b_sel  = sel ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
    assign op_sel = sel ? bus.req_op[5:3] : bus.req_op[2:0];

    alu_exec u_exec (
        .a  (a_sel),
        .b  (b_sel),
        .op (op_sel),
        .y  (alu_y)
    );

    // Next state of the output slot, pointer and result register.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (!accept && bus.rsp_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (accept) begin
            data_d = alu_y;
            id_d   = sel;
            ptr_d  = ~sel;
        end
    end

    // State registers; reset discards any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q == ST_FULL) && !bus.rsp_ready;
    assign state_dbg     = state_q;
    assign ptr_dbg       = ptr_q;

endmodule
